// File: rtl/dmem_responder_pkg.sv
// Shared constants, FSM state type and address helpers for the D-MEM responder.
// Address map: low 64 KiB is RAM; 0xFFFF_F000 is the LED register when DMEM_MMIO_EN is defined.
package dmem_responder_pkg;

    localparam int DBITS        = 32;
    localparam int DMEMADDRBITS = 16;
    localparam int DMEMWORDBITS = 2;
    localparam int DMEMIDXBITS  = DMEMADDRBITS - DMEMWORDBITS;
    localparam int DMEMWORDS    = 1 << DMEMIDXBITS;

    localparam logic [31:0] ADDR_LEDR = 32'hFFFF_F000;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    function automatic logic [DMEMIDXBITS-1:0] word_idx(input logic [31:0] addr);
        return addr[DMEMADDRBITS-1:DMEMWORDBITS];
    endfunction

endpackage

// File: rtl/dmem_responder_if.sv
// MEM-stage <-> D-MEM request/response channel: valid/ready on both directions.
// master = MEM stage, slave = responder.
interface dmem_responder_if;
    import dmem_responder_pkg::*;

    logic             req_valid;
    logic             req_ready;
    logic             req_we;
    logic [31:0]      req_addr;
    logic [DBITS-1:0] req_wdata;
    logic [3:0]       req_be;
    logic             resp_valid;
    logic             resp_ready;
    logic [DBITS-1:0] resp_rdata;
    logic             resp_err;

    modport master (
        output req_valid, req_we, req_addr, req_wdata, req_be, resp_ready,
        input  req_ready, resp_valid, resp_rdata, resp_err
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata, req_be, resp_ready,
        output req_ready, resp_valid, resp_rdata, resp_err
    );
endinterface

// File: rtl/dmem_responder_array.sv
// D-MEM word array: byte-enabled synchronous write, asynchronous read.
// Latency: write lands at the clock edge, read is combinational.
// Backpressure: none, the responder FSM sequences all accesses.
module dmem_array
    import dmem_responder_pkg::*;
(
    input  logic                   clk,
    input  logic                   i_we,
    input  logic [3:0]             i_be,
    input  logic [DMEMIDXBITS-1:0] i_idx,
    input  logic [DBITS-1:0]       i_wdata,
    output logic [DBITS-1:0]       o_rdata
);

    logic [DBITS-1:0] r_mem [DMEMWORDS];

    always_ff @(posedge clk) begin
        if (i_we) begin
            for (int i = 0; i < 4; i++) begin
                if (i_be[i]) r_mem[i_idx][8*i +: 8] <= i_wdata[8*i +: 8];
            end
        end
    end

    assign o_rdata = r_mem[i_idx];

endmodule

// File: rtl/dmem_responder.sv
// D-MEM responder: one load/store at a time, fixed LATENCY cycles from request handshake to resp_valid.
// Latency: LATENCY (1..15); throughput one access per LATENCY+1 cycles. Optional LED MMIO via DMEM_MMIO_EN.
// Backpressure: req_ready only in IDLE; response held frozen while resp_ready is low.
module dmem_responder
    import dmem_responder_pkg::*;
#(
    parameter int LATENCY = 2
) (
    input  logic              clk,
    input  logic              reset,
    dmem_responder_if.slave   bus
`ifdef DMEM_MMIO_EN
    ,
    output logic [9:0]        ledr
`endif
);

    localparam logic [3:0] LAT_M1 = 4'(LATENCY - 1);

    state_t           r_state;
    logic [3:0]       r_cnt;
    logic             r_we;
    logic [31:0]      r_addr;
    logic [DBITS-1:0] r_wdata;
    logic [3:0]       r_be;
    logic             r_resp_valid;
    logic [DBITS-1:0] r_rdata;
    logic             r_err;

    logic             w_idle;
    logic             w_go;
    logic             w_acc_we;
    logic [31:0]      w_acc_addr;
    logic [DBITS-1:0] w_acc_wdata;
    logic [3:0]       w_acc_be;
    logic             w_in_range;
    logic             w_is_led;
    logic             w_err;
    logic [DBITS-1:0] w_mem_rdata;
    logic [DBITS-1:0] w_led_rdata;
    logic [DBITS-1:0] w_load_data;
    logic             w_unused;

    assign w_idle = (r_state == S_IDLE);

    // With LATENCY==1 the access runs on the handshake edge itself, so it must see the live request.
    assign w_acc_we    = w_idle ? bus.req_we    : r_we;
    assign w_acc_addr  = w_idle ? bus.req_addr  : r_addr;
    assign w_acc_wdata = w_idle ? bus.req_wdata : r_wdata;
    assign w_acc_be    = w_idle ? bus.req_be    : r_be;
    assign w_unused    = ^w_acc_addr[DMEMWORDBITS-1:0];

    assign w_go = !reset &&
                  ((w_idle && bus.req_valid && (LAT_M1 == 4'd0)) ||
                   ((r_state == S_WAIT) && (r_cnt == 4'd1)));

    assign w_in_range = (w_acc_addr[31:DMEMADDRBITS] == '0);

`ifdef DMEM_MMIO_EN
    logic [9:0] r_ledr;

    assign w_is_led    = (w_acc_addr[31:DMEMWORDBITS] == ADDR_LEDR[31:DMEMWORDBITS]);
    assign w_led_rdata = {22'b0, r_ledr};
    assign ledr        = r_ledr;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_ledr <= '0;
        end else if (w_go && w_acc_we && w_is_led) begin
            if (w_acc_be[0]) r_ledr[7:0] <= w_acc_wdata[7:0];
            if (w_acc_be[1]) r_ledr[9:8] <= w_acc_wdata[9:8];
        end
    end
`else
    assign w_is_led    = 1'b0;
    assign w_led_rdata = '0;
`endif

    assign w_err       = !w_in_range && !w_is_led;
    assign w_load_data = (w_err || w_acc_we) ? '0 :
                         w_is_led            ? w_led_rdata : w_mem_rdata;

    dmem_array u_array (
        .clk     (clk),
        .i_we    (w_go && w_acc_we && w_in_range),
        .i_be    (w_acc_be),
        .i_idx   (word_idx(w_acc_addr)),
        .i_wdata (w_acc_wdata),
        .o_rdata (w_mem_rdata)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_cnt        <= '0;
            r_we         <= 1'b0;
            r_addr       <= '0;
            r_wdata      <= '0;
            r_be         <= '0;
            r_resp_valid <= 1'b0;
            r_rdata      <= '0;
            r_err        <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.req_valid) begin
                        r_we    <= bus.req_we;
                        r_addr  <= bus.req_addr;
                        r_wdata <= bus.req_wdata;
                        r_be    <= bus.req_be;
                        r_cnt   <= LAT_M1;
                        if (LAT_M1 == 4'd0) begin
                            r_state      <= S_RESP;
                            r_resp_valid <= 1'b1;
                            r_rdata      <= w_load_data;
                            r_err        <= w_err;
                        end else begin
                            r_state <= S_WAIT;
                        end
                    end
                end
                S_WAIT: begin
                    r_cnt <= r_cnt - 4'd1;
                    if (r_cnt == 4'd1) begin
                        r_state      <= S_RESP;
                        r_resp_valid <= 1'b1;
                        r_rdata      <= w_load_data;
                        r_err        <= w_err;
                    end
                end
                S_RESP: begin
                    if (bus.resp_ready) begin
                        r_state      <= S_IDLE;
                        r_resp_valid <= 1'b0;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.req_ready  = w_idle;
    assign bus.resp_valid = r_resp_valid;
    assign bus.resp_rdata = r_rdata;
    assign bus.resp_err   = r_err;

endmodule

// File: tb/tb_dmem_responder.sv
// Randomized bench for dmem_responder against a word-level memory model.
// Builds with or without DMEM_MMIO_EN.
module tb_dmem_responder;
    localparam int LAT = 2;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    dmem_responder_if bus_if();
`ifdef DMEM_MMIO_EN
    logic [9:0] ledr;
`endif

    dmem_responder #(.LATENCY(LAT)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_if)
`ifdef DMEM_MMIO_EN
        ,
        .ledr  (ledr)
`endif
    );

    int n_checks = 0;
    int n_errors = 0;

    logic [31:0] mem_m [16];
    logic [9:0]  ledr_m = '0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic bit mmio_en();
`ifdef DMEM_MMIO_EN
        return 1'b1;
`else
        return 1'b0;
`endif
    endfunction

    // Full transaction with the model applied; hold = cycles resp_ready stays low after resp_valid.
    task automatic xact(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [3:0] be, input int hold);
        int n;
        bit in_range, is_led, err_e;
        logic [31:0] rd_e;

        n = 0;
        while (bus_if.req_ready !== 1'b1 && n < 20) begin
            step();
            n++;
        end
        chk("req_ready_wait", 32'(bus_if.req_ready), 32'd1);

        bus_if.req_valid  = 1'b1;
        bus_if.req_we     = we;
        bus_if.req_addr   = addr;
        bus_if.req_wdata  = wdata;
        bus_if.req_be     = be;
        bus_if.resp_ready = (hold == 0);
        step();
        bus_if.req_valid = 1'b0;
        bus_if.req_wdata = $urandom;

        n = 1;
        while (bus_if.resp_valid !== 1'b1 && n < 40) begin
            step();
            n++;
        end
        chk("latency", 32'(n), 32'(LAT));

        in_range = (addr >> 16) == 0;
        is_led   = mmio_en() && ((addr >> 2) == (32'hFFFF_F000 >> 2));
        err_e    = !in_range && !is_led;
        rd_e     = 32'h0;
        if (!err_e && !we) rd_e = is_led ? {22'b0, ledr_m} : mem_m[addr[5:2]];
        if (we && in_range) begin
            for (int i = 0; i < 4; i++)
                if (be[i]) mem_m[addr[5:2]][8*i +: 8] = wdata[8*i +: 8];
        end
        if (we && is_led) begin
            if (be[0]) ledr_m[7:0] = wdata[7:0];
            if (be[1]) ledr_m[9:8] = wdata[9:8];
        end

        chk("rdata", bus_if.resp_rdata, rd_e);
        chk("err", 32'(bus_if.resp_err), 32'(err_e));
        for (int h = 0; h < hold; h++) begin
            step();
            chk("hold_valid", 32'(bus_if.resp_valid), 32'd1);
            chk("hold_rdata", bus_if.resp_rdata, rd_e);
            chk("hold_req_ready", 32'(bus_if.req_ready), 32'd0);
        end
        bus_if.resp_ready = 1'b1;
        step();
        chk("resp_done", 32'(bus_if.resp_valid), 32'd0);
        chk("ready_again", 32'(bus_if.req_ready), 32'd1);
`ifdef DMEM_MMIO_EN
        chk("ledr", 32'(ledr), 32'(ledr_m));
`endif
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] a, d;
        bus_if.req_valid  = 1'b0;
        bus_if.req_we     = 1'b0;
        bus_if.req_addr   = '0;
        bus_if.req_wdata  = '0;
        bus_if.req_be     = '0;
        bus_if.resp_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        step();
        chk("rst_req_ready", 32'(bus_if.req_ready), 32'd1);
        chk("rst_resp_valid", 32'(bus_if.resp_valid), 32'd0);
        chk("rst_rdata", bus_if.resp_rdata, 32'd0);
        chk("rst_err", 32'(bus_if.resp_err), 32'd0);
`ifdef DMEM_MMIO_EN
        chk("rst_ledr", 32'(ledr), 32'd0);
`endif

        // Fill the word pool at 0x00..0x3C so every later load has a known value.
        for (int i = 0; i < 16; i++) xact(1'b1, 32'(i * 4), $urandom, 4'hF, 0);

        xact(1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 0);
        xact(1'b0, 32'h10, 32'h0, 4'h0, 0);
        xact(1'b1, 32'h20, 32'h11223344, 4'hF, 0);
        xact(1'b1, 32'h20, 32'h0000AA00, 4'b0010, 0);
        xact(1'b0, 32'h20, 32'h0, 4'h0, 0);
        chk("byte_merge", mem_m[8], 32'h1122AA44);
        xact(1'b0, 32'h0001_0000, 32'h0, 4'h0, 0);
        xact(1'b1, 32'h0001_0000, 32'hCAFEF00D, 4'hF, 0);
        xact(1'b0, 32'h0000_0000, 32'h0, 4'h0, 0);
        xact(1'b1, 32'h3C, 32'h12345678, 4'h0, 0);
        xact(1'b0, 32'h3C, 32'h0, 4'h0, 0);
        xact(1'b0, 32'h10, 32'h0, 4'h0, 5);

        // Reset while the store to 0x30 waits: store must be dropped.
        bus_if.req_valid = 1'b1;
        bus_if.req_we    = 1'b1;
        bus_if.req_addr  = 32'h30;
        bus_if.req_wdata = ~mem_m[12];
        bus_if.req_be    = 4'hF;
        step();
        bus_if.req_valid = 1'b0;
        chk("wait_req_ready", 32'(bus_if.req_ready), 32'd0);
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("mid_rst_valid", 32'(bus_if.resp_valid), 32'd0);
        chk("mid_rst_ready", 32'(bus_if.req_ready), 32'd1);
        step();
        chk("post_rst_valid", 32'(bus_if.resp_valid), 32'd0);
`ifdef DMEM_MMIO_EN
        ledr_m = '0;
`endif
        xact(1'b0, 32'h30, 32'h0, 4'h0, 0);

        xact(1'b1, 32'hFFFF_F000, 32'h0000_03FF, 4'h3, 0);
        xact(1'b0, 32'hFFFF_F000, 32'h0, 4'h0, 0);
        xact(1'b0, 32'hFFFF_F004, 32'h0, 4'h0, 0);

        for (int k = 0; k < 80; k++) begin
            case ($urandom_range(0, 5))
                0:       a = $urandom | 32'h0001_0000;
                1:       a = 32'hFFFF_F000 | 32'($urandom_range(0, 7));
                default: a = 32'($urandom_range(0, 63));
            endcase
            d = $urandom;
            xact(1'($urandom_range(0, 1)), a, d, 4'($urandom_range(0, 15)), $urandom_range(0, 3));
        end

        for (int i = 0; i < 16; i++) xact(1'b0, 32'(i * 4), 32'h0, 4'h0, 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
